dp_ram_rd_arbiter: RTL and testbench

Shares the single read port of the `dp_ram` line buffer between `NUM_CLIENTS` read requesters using round-robin arbitration, while passing one non-stallable write stream straight to the write port. It sits between the decoder's buffer consumers and the `dp_ram` instance it owns. It returns read data on a shared bus with a one-hot per-client valid one cycle after grant.

---
 rtl/dp_ram_arb_pkg.sv | 11 +
 rtl/dp_ram.sv | 29 ++
 rtl/dp_ram_rd_arbiter.sv | 112 +++++++++++
 tb/tb_dp_ram_rd_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dp_ram_arb_pkg.sv
// Shared constants and helpers for the dp_ram read arbiter.
package dp_ram_arb_pkg;

  localparam int DEF_NUM_CLIENTS = 4;

  // Width of a client index; a single bit still covers the two-client minimum.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port line buffer: one write port, one registered read port,
// read-before-write on a same-address collision. Contents have no reset.
module dp_ram #(
  parameter int NUMBER_OF_LINES = 8192,
  parameter int DATA_WIDTH      = 128,
  parameter int AW              = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [AW-1:0]         addr_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic                  r_en,
  input  logic [AW-1:0]         addr_r,
  output logic [DATA_WIDTH-1:0] data_r,
  output logic                  mem_valid
);

  logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];

  always_ff @(posedge clk) begin
    if (w_en) mem[addr_w] <= data_w;
  end

  always_ff @(posedge clk) begin
    if (r_en) data_r <= mem[addr_r];
    mem_valid <= r_en;
  end

endmodule

// File: rtl/dp_ram_rd_arbiter.sv
// Round-robin sharing of the dp_ram read port among NUM_CLIENTS requesters;
// writes pass straight through. Optional DP_RAM_ARB_WR_BYPASS_EN makes a
// same-cycle same-address write/read return the new data.
module dp_ram_rd_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int NUMBER_OF_LINES = 8192,
  parameter int DATA_WIDTH      = 128,
  parameter int NUM_CLIENTS     = DEF_NUM_CLIENTS,
  localparam int AW             = $clog2(NUMBER_OF_LINES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [NUM_CLIENTS-1:0]    rd_req,
  input  logic [NUM_CLIENTS*AW-1:0] rd_addr,
  output logic [NUM_CLIENTS-1:0]    rd_gnt,
  output logic [NUM_CLIENTS-1:0]    rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  localparam int CW = idx_w(NUM_CLIENTS);

  logic [CW-1:0]         rr_ptr, gnt_idx, tag_id;
  logic                  found, tag_vld;
  logic [AW-1:0]         addr_r;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_valid_unused;

  // Search from rr_ptr upward with explicit wrap, so any client count works.
  always_comb begin : rr_search
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int off = 0; off < NUM_CLIENTS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && rd_req[CW'(idx)]) begin
        found   = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  always_comb begin
    rd_gnt = '0;
    addr_r = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rd_gnt[i] = found && (gnt_idx == CW'(i));
      if (rd_gnt[i]) addr_r = rd_addr[i*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      tag_vld <= 1'b0;
      tag_id  <= '0;
    end else begin
      tag_vld <= found;
      if (found) begin
        tag_id <= gnt_idx;
        rr_ptr <= (gnt_idx == CW'(NUM_CLIENTS-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_vld
    assign rd_valid[g] = tag_vld && (tag_id == CW'(g));
  end

  dp_ram #(
    .NUMBER_OF_LINES (NUMBER_OF_LINES),
    .DATA_WIDTH      (DATA_WIDTH),
    .AW              (AW)
  ) u_ram (
    .clk       (clk),
    .w_en      (wr_en),
    .addr_w    (wr_addr),
    .data_w    (wr_data),
    .r_en      (found),
    .addr_r    (addr_r),
    .data_r    (ram_q),
    .mem_valid (ram_valid_unused)
  );

`ifdef DP_RAM_ARB_WR_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;
  logic                  collide;

  assign collide = wr_en && found && (wr_addr == addr_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= collide;
      if (collide) byp_data <= wr_data;
    end
  end

  assign rd_data = !tag_vld ? '0 : (byp_hit ? byp_data : ram_q);
`else
  assign rd_data = tag_vld ? ram_q : '0;
`endif

endmodule

// File: tb/tb_dp_ram_rd_arbiter.sv
// Directed bench for dp_ram_rd_arbiter: a 4-client and a 3-client instance
// sharing clock, reset and the write stream.
module tb_dp_ram_rd_arbiter;

  localparam int AW = 13;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0] rd_req, rd_gnt, rd_valid;
  logic [4*AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [2:0] rd_req3, rd_gnt3, rd_valid3;
  logic [3*AW-1:0] rd_addr3;
  logic [DW-1:0] rd_data3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dp_ram_rd_arbiter #(.NUMBER_OF_LINES(8192), .DATA_WIDTH(DW), .NUM_CLIENTS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  dp_ram_rd_arbiter #(.NUMBER_OF_LINES(8192), .DATA_WIDTH(DW), .NUM_CLIENTS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_gnt(rd_gnt3), .rd_valid(rd_valid3), .rd_data(rd_data3)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [3:0]    eg;
    logic [DW-1:0] coll_exp;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = '0; rd_addr = '0; rd_req3 = '0; rd_addr3 = '0;
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_gnt", rd_gnt, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Preload
    wr(13'h010, 128'hA5);
    wr(13'h005, 128'h11);
    for (int i = 0; i < 4; i++) wr(AW'(13'h020 + i), DW'(128'h100 + i));

    // Single request from client 2
    rd_addr[2*AW +: AW] = 13'h010; rd_req = 4'b0100; #1;
    chk("t1_gnt", rd_gnt, 4'b0100);
    tick(); rd_req = '0;
    chk("t1_valid", rd_valid, 4'b0100);
    chk("t1_data", rd_data, 128'hA5);
    // Pointer now 3: client 3 beats client 0
    rd_addr[0 +: AW] = 13'h020; rd_addr[3*AW +: AW] = 13'h023; rd_req = 4'b1001; #1;
    chk("t1_ptr_gnt", rd_gnt, 4'b1000);
    tick(); rd_req = '0;
    chk("t1_ptr_valid", rd_valid, 4'b1000);
    chk("t1_ptr_data", rd_data, 128'h103);

    // All four continuously from reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = AW'(13'h020 + i);
    rd_req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      eg = 4'b0001 << (c % 4);
      #1;
      chk("rr_gnt", rd_gnt, eg);
      tick();
      if (c == 7) rd_req = '0;
      chk("rr_valid", rd_valid, eg);
      chk("rr_data", rd_data, DW'(128'h100 + (c % 4)));
    end

    // Same-address write/read collision
`ifdef DP_RAM_ARB_WR_BYPASS_EN
    coll_exp = 128'h22;
`else
    coll_exp = 128'h11;
`endif
    rd_addr[0 +: AW] = 13'h005; rd_req = 4'b0001;
    wr_en = 1'b1; wr_addr = 13'h005; wr_data = 128'h22; #1;
    chk("coll_gnt", rd_gnt, 4'b0001);
    tick(); wr_en = 1'b0; rd_req = '0;
    chk("coll_data", rd_data, coll_exp);
    rd_addr[AW +: AW] = 13'h005; rd_req = 4'b0010; #1;
    chk("coll_rb_gnt", rd_gnt, 4'b0010);
    tick(); rd_req = '0;
    chk("coll_rb_data", rd_data, 128'h22);

    // Reset while a read is in flight
    rd_addr[2*AW +: AW] = 13'h010; rd_req = 4'b0100; #1;
    chk("mid_gnt", rd_gnt, 4'b0100);
    rst_n = 1'b0; #1;
    tick(); rd_req = '0;
    chk("mid_valid0", rd_valid, 0);
    chk("mid_data0", rd_data, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_valid1", rd_valid, 0);
    rd_addr[0 +: AW] = 13'h020; rd_addr[3*AW +: AW] = 13'h023; rd_req = 4'b1001; #1;
    chk("mid_prio_gnt", rd_gnt, 4'b0001);
    tick(); rd_req = '0;
    chk("mid_prio_valid", rd_valid, 4'b0001);
    chk("mid_prio_data", rd_data, 128'h100);

    // Idle reads with writes active
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = AW'(13'h030 + i); wr_data = DW'(128'h200 + i); #1;
      chk("idle_gnt", rd_gnt, 0);
      tick();
      chk("idle_valid", rd_valid, 0);
      chk("idle_data", rd_data, 0);
    end
    wr_en = 1'b0;
    rd_addr[AW +: AW] = 13'h032; rd_req = 4'b0010; #1;
    chk("idle_rb_gnt", rd_gnt, 4'b0010);
    tick(); rd_req = '0;
    chk("idle_rb_data", rd_data, 128'h202);

    // Three clients: wrap with a non-power-of-two count
    rd_addr3[0 +: AW] = 13'h020; rd_addr3[AW +: AW] = 13'h010; rd_addr3[2*AW +: AW] = 13'h023;
    rd_req3 = 3'b010; #1;
    chk("n3_gnt1", rd_gnt3, 3'b010);
    tick(); rd_req3 = 3'b101;
    chk("n3_valid1", rd_valid3, 3'b010);
    chk("n3_data1", rd_data3, 128'hA5);
    #1;
    chk("n3_gnt2", rd_gnt3, 3'b100);
    tick();
    chk("n3_valid2", rd_valid3, 3'b100);
    chk("n3_data2", rd_data3, 128'h103);
    #1;
    chk("n3_gnt0", rd_gnt3, 3'b001);
    tick();
    chk("n3_valid0", rd_valid3, 3'b001);
    chk("n3_data0", rd_data3, 128'h100);
    #1;
    chk("n3_gnt2b", rd_gnt3, 3'b100);
    tick(); rd_req3 = '0;
    chk("n3_valid2b", rd_valid3, 3'b100);
    tick();
    chk("n3_idle", rd_valid3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
